// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT sequencer
// with combinational strobes and a saturating retired-instruction counter.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             ir_we,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             pc_en,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [6:0]       opc_q, opc_d;
  logic [CNT_W-1:0] cnt_q;

  logic retire;
  logic ir_we_c, reg_we_c, mem_re_c, mem_we_c, pc_en_c, pc_sel_c, halted_c;

  always_comb begin
    state_d  = FETCH;
    opc_d    = opc_q;
    retire   = 1'b0;
    ir_we_c  = 1'b0;
    reg_we_c = 1'b0;
    mem_re_c = 1'b0;
    mem_we_c = 1'b0;
    pc_en_c  = 1'b0;
    pc_sel_c = 1'b0;
    halted_c = 1'b0;
    case (state_q)
      FETCH: begin
        ir_we_c = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        opc_d   = opcode;
        state_d = (opcode == OP_HALT) ? HALT : EXECUTE;
      end
      EXECUTE: begin
        case (opc_q)
          OP_LOAD, OP_STORE: state_d = MEMORY;
          OP_BRANCH: begin
            pc_en_c  = 1'b1;
            pc_sel_c = branch_taken;
            retire   = 1'b1;
            state_d  = FETCH;
          end
          OP_RTYPE, OP_ITYPE, OP_LUI, OP_JAL: state_d = WRITEBACK;
          default: begin
            pc_en_c = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMORY: begin
        mem_re_c = (opc_q == OP_LOAD);
        mem_we_c = (opc_q == OP_STORE);
        if (!mem_ready) begin
          state_d = MEMORY;
        end else if (opc_q == OP_LOAD) begin
          state_d = WRITEBACK;
        end else begin
          pc_en_c = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      WRITEBACK: begin
        reg_we_c = 1'b1;
        pc_en_c  = 1'b1;
        pc_sel_c = (opc_q == OP_JAL);
        retire   = 1'b1;
        state_d  = FETCH;
      end
      HALT: begin
        halted_c = 1'b1;
        if (resume) begin
          pc_en_c = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = HALT;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      opc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      if (retire && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  // Strobes are gated by rst so nothing leaks out while reset is held.
  assign ir_we       = ir_we_c  & ~rst;
  assign reg_we      = reg_we_c & ~rst;
  assign mem_re      = mem_re_c & ~rst;
  assign mem_we      = mem_we_c & ~rst;
  assign pc_en       = pc_en_c  & ~rst;
  assign pc_sel      = pc_sel_c & ~rst;
  assign halted      = halted_c & ~rst;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; a CNT_W=4 copy shares the
// stimulus so counter saturation can be observed quickly.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        branchTaken;
  logic        memReady;
  logic        resume;

  logic        irWe, regWe, memRe, memWe, pcEn, pcSel, halted;
  logic [2:0]  state;
  logic [15:0] cnt;

  logic        irWe4, regWe4, memRe4, memWe4, pcEn4, pcSel4, halted4;
  logic [2:0]  state4;
  logic [3:0]  cnt4;

  // {state, ir_we, reg_we, mem_re, mem_we, pc_en, pc_sel, halted}
  logic [9:0]  obs;
  assign obs = {state, irWe, regWe, memRe, memWe, pcEn, pcSel, halted};

  int nCmp  = 0;
  int nFail = 0;
  int expCnt = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branchTaken),
    .mem_ready(memReady), .resume(resume),
    .ir_we(irWe), .reg_we(regWe), .mem_re(memRe), .mem_we(memWe),
    .pc_en(pcEn), .pc_sel(pcSel), .state(state), .halted(halted),
    .instr_count(cnt)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branchTaken),
    .mem_ready(memReady), .resume(resume),
    .ir_we(irWe4), .reg_we(regWe4), .mem_re(memRe4), .mem_we(memWe4),
    .pc_en(pcEn4), .pc_sel(pcSel4), .state(state4), .halted(halted4),
    .instr_count(cnt4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = '0; branchTaken = 1'b0; memReady = 1'b0; resume = 1'b0;
    repeat (2) tick();
    nCmp++; if (obs !== 10'b000_0000000) begin nFail++; $display("[TB] FAIL reset_obs: got %b want %b", obs, 10'b000_0000000); end
    nCmp++; if (cnt !== 16'd0) begin nFail++; $display("[TB] FAIL reset_cnt: got %0d want 0", cnt); end
    rst = 1'b0;
    #1;
    nCmp++; if (obs !== {3'd0, 7'b1000000}) begin nFail++; $display("[TB] FAIL reset_first_fetch: got %b want %b", obs, {3'd0, 7'b1000000}); end
    expCnt = 0;
  endtask

  task automatic test_rtype();
    opcode = 7'b0110011;
    tick();
    nCmp++; if (obs !== {3'd1, 7'b0000000}) begin nFail++; $display("[TB] FAIL rtype_decode: got %b want %b", obs, {3'd1, 7'b0000000}); end
    tick();
    nCmp++; if (obs !== {3'd2, 7'b0000000}) begin nFail++; $display("[TB] FAIL rtype_execute: got %b want %b", obs, {3'd2, 7'b0000000}); end
    tick();
    nCmp++; if (obs !== {3'd4, 7'b0100100}) begin nFail++; $display("[TB] FAIL rtype_writeback: got %b want %b", obs, {3'd4, 7'b0100100}); end
    tick();
    expCnt++;
    nCmp++; if (obs !== {3'd0, 7'b1000000}) begin nFail++; $display("[TB] FAIL rtype_fetch: got %b want %b", obs, {3'd0, 7'b1000000}); end
    nCmp++; if (cnt !== 16'(expCnt)) begin nFail++; $display("[TB] FAIL rtype_cnt: got %0d want %0d", cnt, expCnt); end
  endtask

  task automatic test_load_wait();
    opcode = 7'b0000011; memReady = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      nCmp++; if (obs !== {3'd3, 7'b0010000}) begin nFail++; $display("[TB] FAIL load_wait%0d: got %b want %b", i, obs, {3'd3, 7'b0010000}); end
      tick();
    end
    memReady = 1'b1;
    #1;
    nCmp++; if (obs !== {3'd3, 7'b0010000}) begin nFail++; $display("[TB] FAIL load_ready: got %b want %b", obs, {3'd3, 7'b0010000}); end
    tick();
    memReady = 1'b0;
    nCmp++; if (obs !== {3'd4, 7'b0100100}) begin nFail++; $display("[TB] FAIL load_writeback: got %b want %b", obs, {3'd4, 7'b0100100}); end
    tick();
    expCnt++;
    nCmp++; if (cnt !== 16'(expCnt)) begin nFail++; $display("[TB] FAIL load_cnt: got %0d want %0d", cnt, expCnt); end
  endtask

  task automatic test_store();
    opcode = 7'b0100011; memReady = 1'b0;
    repeat (3) tick();
    nCmp++; if (obs !== {3'd3, 7'b0001000}) begin nFail++; $display("[TB] FAIL store_wait: got %b want %b", obs, {3'd3, 7'b0001000}); end
    tick();
    memReady = 1'b1;
    #1;
    nCmp++; if (obs !== {3'd3, 7'b0001100}) begin nFail++; $display("[TB] FAIL store_ready: got %b want %b", obs, {3'd3, 7'b0001100}); end
    tick();
    memReady = 1'b0;
    expCnt++;
    nCmp++; if (obs !== {3'd0, 7'b1000000}) begin nFail++; $display("[TB] FAIL store_fetch: got %b want %b", obs, {3'd0, 7'b1000000}); end
    nCmp++; if (cnt !== 16'(expCnt)) begin nFail++; $display("[TB] FAIL store_cnt: got %0d want %0d", cnt, expCnt); end
  endtask

  task automatic test_branch();
    opcode = 7'b1100011;
    repeat (2) tick();
    branchTaken = 1'b1;
    #1;
    nCmp++; if (obs !== {3'd2, 7'b0000110}) begin nFail++; $display("[TB] FAIL branch_taken: got %b want %b", obs, {3'd2, 7'b0000110}); end
    branchTaken = 1'b0;
    #1;
    nCmp++; if (obs !== {3'd2, 7'b0000100}) begin nFail++; $display("[TB] FAIL branch_not_taken: got %b want %b", obs, {3'd2, 7'b0000100}); end
    tick();
    expCnt++;
    nCmp++; if (obs !== {3'd0, 7'b1000000}) begin nFail++; $display("[TB] FAIL branch_fetch: got %b want %b", obs, {3'd0, 7'b1000000}); end
    nCmp++; if (cnt !== 16'(expCnt)) begin nFail++; $display("[TB] FAIL branch_cnt: got %0d want %0d", cnt, expCnt); end
  endtask

  task automatic test_writeback_ops();
    logic [6:0] ops [3];
    logic       sel [3];
    ops[0] = 7'b0010011; sel[0] = 1'b0;
    ops[1] = 7'b0110111; sel[1] = 1'b0;
    ops[2] = 7'b1101111; sel[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = ops[i];
      repeat (3) tick();
      nCmp++; if (obs !== {3'd4, 4'b0100, 1'b1, sel[i], 1'b0}) begin nFail++; $display("[TB] FAIL wb_op%0d: got %b want %b", i, obs, {3'd4, 4'b0100, 1'b1, sel[i], 1'b0}); end
      tick();
      expCnt++;
    end
    nCmp++; if (cnt !== 16'(expCnt)) begin nFail++; $display("[TB] FAIL wb_cnt: got %0d want %0d", cnt, expCnt); end
  endtask

  task automatic test_halt();
    opcode = 7'b1111111; resume = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      nCmp++; if (obs !== {3'd5, 7'b0000001}) begin nFail++; $display("[TB] FAIL halt_hold%0d: got %b want %b", i, obs, {3'd5, 7'b0000001}); end
      tick();
    end
    nCmp++; if (cnt !== 16'(expCnt)) begin nFail++; $display("[TB] FAIL halt_cnt_hold: got %0d want %0d", cnt, expCnt); end
    resume = 1'b1;
    #1;
    nCmp++; if (obs !== {3'd5, 7'b0000101}) begin nFail++; $display("[TB] FAIL halt_resume: got %b want %b", obs, {3'd5, 7'b0000101}); end
    tick();
    resume = 1'b0;
    expCnt++;
    nCmp++; if (obs !== {3'd0, 7'b1000000}) begin nFail++; $display("[TB] FAIL halt_exit: got %b want %b", obs, {3'd0, 7'b1000000}); end
    nCmp++; if (cnt !== 16'(expCnt)) begin nFail++; $display("[TB] FAIL halt_cnt: got %0d want %0d", cnt, expCnt); end
  endtask

  task automatic test_resume_ignored();
    opcode = 7'b0000000; resume = 1'b1;
    #1;
    nCmp++; if (obs !== {3'd0, 7'b1000000}) begin nFail++; $display("[TB] FAIL resume_fetch: got %b want %b", obs, {3'd0, 7'b1000000}); end
    tick();
    nCmp++; if (obs !== {3'd1, 7'b0000000}) begin nFail++; $display("[TB] FAIL resume_decode: got %b want %b", obs, {3'd1, 7'b0000000}); end
    tick();
    nCmp++; if (obs !== {3'd2, 7'b0000100}) begin nFail++; $display("[TB] FAIL resume_nop: got %b want %b", obs, {3'd2, 7'b0000100}); end
    resume = 1'b0;
    tick();
    expCnt++;
    nCmp++; if (cnt !== 16'(expCnt)) begin nFail++; $display("[TB] FAIL nop_cnt: got %0d want %0d", cnt, expCnt); end
  endtask

  task automatic test_reset_mid_memory();
    opcode = 7'b0000011; memReady = 1'b0;
    repeat (3) tick();
    nCmp++; if (obs !== {3'd3, 7'b0010000}) begin nFail++; $display("[TB] FAIL midrst_pre: got %b want %b", obs, {3'd3, 7'b0010000}); end
    #2;
    rst = 1'b1;
    #1;
    nCmp++; if (obs !== 10'b000_0000000) begin nFail++; $display("[TB] FAIL midrst_obs: got %b want %b", obs, 10'b000_0000000); end
    nCmp++; if (cnt !== 16'd0) begin nFail++; $display("[TB] FAIL midrst_cnt: got %0d want 0", cnt); end
    tick();
    rst = 1'b0;
    expCnt = 0;
    #1;
    nCmp++; if (obs !== {3'd0, 7'b1000000}) begin nFail++; $display("[TB] FAIL midrst_release: got %b want %b", obs, {3'd0, 7'b1000000}); end
  endtask

  task automatic test_saturation();
    int exp4;
    opcode = 7'b0000000;
    for (int i = 1; i <= 17; i++) begin
      repeat (3) tick();
      expCnt++;
      exp4 = (i > 15) ? 15 : i;
      if (i >= 14) begin
        nCmp++; if (cnt4 !== 4'(exp4)) begin nFail++; $display("[TB] FAIL sat_cnt4_%0d: got %0d want %0d", i, cnt4, exp4); end
      end
    end
    nCmp++; if (cnt !== 16'(expCnt)) begin nFail++; $display("[TB] FAIL sat_cnt16: got %0d want %0d", cnt, expCnt); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_branch();
    test_writeback_ops();
    test_halt();
    test_resume_ignored();
    test_reset_mid_memory();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The module SHALL have one parameter: CNT_W, default 16, the width of the retired-instruction counter.
REQ-002 The module SHALL have port clk, input, 1 bit, the rising-edge clock of the single clock domain.
REQ-003 The module SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-004 The module SHALL have port opcode, input, 7 bits, the opcode of the fetched instruction, sampled in DECODE.
REQ-005 The module SHALL have port branch_taken, input, 1 bit, the ALU branch-compare result, sampled in EXECUTE.
REQ-006 The module SHALL have port mem_ready, input, 1 bit, the data-memory completion handshake.
REQ-007 The module SHALL have port resume, input, 1 bit, the request to leave HALT.
REQ-008 The module SHALL have ports ir_we, reg_we, mem_re, mem_we, pc_en and pc_sel, each an output of 1 bit: the IR write, register-file write, memory read and write strobes, the PC advance enable, and the PC source (0 = +1, 1 = target).
REQ-009 The module SHALL have port state, output, 3 bits, the current FSM state.
REQ-010 The module SHALL have port halted, output, 1 bit, high while in HALT.
REQ-011 The module SHALL have port instr_count, output, CNT_W bits, the count of retired instructions.

Function
REQ-012 The FSM state encodings SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5; codes 6-7 SHALL go to FETCH on the next edge with all strobes low.
REQ-013 All strobes SHALL be combinational from the state, the latched opcode (opc_q) and, where stated, branch_taken and mem_ready; every strobe is 0 unless a rule below sets it.
REQ-014 In FETCH: ir_we=1; next state DECODE.
REQ-015 In DECODE: opc_q <= opcode; 7'b1111111 -> HALT; any other value -> EXECUTE.
REQ-016 In EXECUTE, for opc_q 0000011 (load) or 0100011 (store): next state MEMORY.
REQ-017 In EXECUTE, for opc_q 1100011 (branch): pc_en=1, pc_sel=branch_taken; next state FETCH; the instruction retires.
REQ-018 In EXECUTE, for opc_q 0110011, 0010011, 0110111 or 1101111: next state WRITEBACK.
REQ-019 In EXECUTE, for any other opc_q: treat as NOP, pc_en=1, pc_sel=0; next state FETCH; the instruction retires.
REQ-020 In MEMORY: mem_re=1 for load and mem_we=1 for store, held every cycle until mem_ready=1 with no timeout.
REQ-021 In MEMORY with mem_ready=1: a load goes to WRITEBACK; a store sets pc_en=1, pc_sel=0, goes to FETCH and retires.
REQ-022 In WRITEBACK: reg_we=1, pc_en=1, pc_sel=1 only for opc_q 1101111 (jal) else 0; next state FETCH; the instruction retires.
REQ-023 In HALT: halted=1 and pc_en=0.
REQ-024 In HALT with resume=1: pc_en=1, pc_sel=0; next state FETCH; the halt instruction retires; resume is ignored in all other states.
REQ-025 instr_count SHALL increment by 1 on each clock edge ending a retiring cycle, saturating at all-ones with no wrap.
REQ-026 pc_en SHALL be high for at most one cycle per instruction.
REQ-027 ir_we SHALL be high only in FETCH.

Reset
REQ-028 While rst=1, state SHALL be FETCH, opc_q=0 and instr_count=0, all taking effect asynchronously.
REQ-029 While rst=1, all strobes and halted SHALL be forced to 0.
REQ-030 After rst falls, the first rising clock edge SHALL execute FETCH, with ir_we=1 in the first cycle.
REQ-031 A reset mid-operation, including during a MEMORY wait, SHALL abandon the instruction without retiring it.

Verification
REQ-032 R-type (0110011) after reset: states 0,1,2,4 then 0; reg_we=1 and pc_en=1 only in cycle 4; instr_count=1.
REQ-033 Load with mem_ready low for 3 cycles: MEMORY is held 4 cycles with mem_re=1 throughout, then WRITEBACK with reg_we=1, pc_en=1.
REQ-034 Branch with branch_taken=1: in EXECUTE pc_en=1, pc_sel=1, reg_we=0; next state FETCH; a not-taken branch gives pc_sel=0.
REQ-035 Opcode 1111111: state 5 and halted=1 with pc_en=0 for 10 cycles; resume pulse -> pc_en=1 for one cycle, state 0, instr_count+1.
REQ-036 rst asserted mid-MEMORY between clock edges: state=0, mem_re=0 and instr_count=0 before the next edge.
REQ-037 With CNT_W=4, 17 NOPs (opcode 0000000): instr_count stops at 15.
